// File: rtl/simd_lane_alu.sv
// Multi-cycle signed SIMD add/sub/mul over 8/16/32/64-bit lanes, one 64-bit chunk per cycle.
// Full 2N-bit lane results are published atomically to ldata/hdata when entering DONE.
module simd_lane_alu #(
    parameter int unsigned DATA_W  = 512,
    parameter int unsigned CHUNK_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] ldata,
    output logic [DATA_W-1:0] hdata,
    output logic              busy,
    output logic              done,
    output logic              select
);

    localparam int unsigned NCHUNK = DATA_W / CHUNK_W;
    localparam int unsigned CW     = $clog2(NCHUNK);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] a_q, b_q;
    logic [1:0]        op_q, mode_q;
    logic [DATA_W-1:0] lres, hres;
    logic [DATA_W-1:0] lnext, hnext;
    logic [CHUNK_W-1:0] ca, cb, cl, ch;
    logic [127:0]      r;

    // Operands arrive sign-extended to 128 bits, so the low 2N bits of the result are exact.
    function automatic logic [127:0] lane_op(input logic [1:0] o,
                                             input logic signed [127:0] x,
                                             input logic signed [127:0] y);
        case (o)
            2'b01:   lane_op = x - y;
            2'b10:   lane_op = x * y;
            default: lane_op = x + y;
        endcase
    endfunction

    always_comb begin
        ca = a_q[cnt*CHUNK_W +: CHUNK_W];
        cb = b_q[cnt*CHUNK_W +: CHUNK_W];
        cl = '0;
        ch = '0;
        r  = '0;
        case (mode_q)
            2'b00: begin
                for (int i = 0; i < int'(CHUNK_W / 8); i++) begin
                    r = lane_op(op_q, {{120{ca[i*8+7]}}, ca[i*8 +: 8]},
                                      {{120{cb[i*8+7]}}, cb[i*8 +: 8]});
                    cl[i*8 +: 8] = r[7:0];
                    ch[i*8 +: 8] = r[15:8];
                end
            end
            2'b01: begin
                for (int i = 0; i < int'(CHUNK_W / 16); i++) begin
                    r = lane_op(op_q, {{112{ca[i*16+15]}}, ca[i*16 +: 16]},
                                      {{112{cb[i*16+15]}}, cb[i*16 +: 16]});
                    cl[i*16 +: 16] = r[15:0];
                    ch[i*16 +: 16] = r[31:16];
                end
            end
            2'b10: begin
                for (int i = 0; i < int'(CHUNK_W / 32); i++) begin
                    r = lane_op(op_q, {{96{ca[i*32+31]}}, ca[i*32 +: 32]},
                                      {{96{cb[i*32+31]}}, cb[i*32 +: 32]});
                    cl[i*32 +: 32] = r[31:0];
                    ch[i*32 +: 32] = r[63:32];
                end
            end
            default: begin
                for (int i = 0; i < int'(CHUNK_W / 64); i++) begin
                    r = lane_op(op_q, {{64{ca[i*64+63]}}, ca[i*64 +: 64]},
                                      {{64{cb[i*64+63]}}, cb[i*64 +: 64]});
                    cl[i*64 +: 64] = r[63:0];
                    ch[i*64 +: 64] = r[127:64];
                end
            end
        endcase
        lnext = lres;
        hnext = hres;
        lnext[cnt*CHUNK_W +: CHUNK_W] = cl;
        hnext[cnt*CHUNK_W +: CHUNK_W] = ch;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            mode_q <= '0;
            lres   <= '0;
            hres   <= '0;
            ldata  <= '0;
            hdata  <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        a_q    <= a;
                        b_q    <= b;
                        op_q   <= op;
                        mode_q <= mode;
                        cnt    <= '0;
                        state  <= S_CALC;
                    end else begin
                        state  <= S_IDLE;
                    end
                end
                S_CALC: begin
                    lres <= lnext;
                    hres <= hnext;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(NCHUNK - 1)) begin
                        // Final chunk goes straight to the outputs so all lanes appear together.
                        ldata <= lnext;
                        hdata <= hnext;
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy   = (state == S_CALC);
    assign done   = (state == S_DONE);
    assign select = done;

endmodule
